// File: rtl/im_access_ctrl.sv
// Instruction-memory port arbiter: shares one single-port IM between the fetch
// stage (reads) and the program loader (writes), with a starvation guard for fetch.
module im_access_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int LD_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_inst,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic              im_read,
    output logic              im_write,
    output logic [ADDR_W-1:0] im_address,
    output logic [DATA_W-1:0] im_wdata,
    input  logic [DATA_W-1:0] im_rdata
);

    localparam int RUN_W = $clog2(LD_MAX + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LD_MAX);

    localparam logic [1:0] OWN_IDLE  = 2'd0;
    localparam logic [1:0] OWN_FETCH = 2'd1;
    localparam logic [1:0] OWN_LOAD  = 2'd2;

    logic [1:0]        owner_reg, owner_next;
    logic [RUN_W-1:0]  ld_run_reg, ld_run_next;
    logic [DATA_W-1:0] if_inst_reg;
    logic              fetch_elig;
    logic              fetch_win;

    // The loader normally wins; fetch only overrides once the loader has had
    // LD_MAX consecutive grants while fetch was waiting.
    assign fetch_elig = if_req & ~if_flush;
    assign fetch_win  = fetch_elig & (~ld_req | (ld_run_reg == RUN_MAX));

    // Grants are suppressed during reset so the memory sees no traffic.
    assign if_gnt = rst & fetch_win;
    assign ld_gnt = rst & ld_req & ~fetch_win;

    always_comb begin
        im_read    = 1'b0;
        im_write   = 1'b0;
        im_address = '0;
        im_wdata   = '0;
        if (if_gnt) begin
            im_read    = 1'b1;
            im_address = if_addr;
        end else if (ld_gnt) begin
            im_write   = 1'b1;
            im_address = ld_addr;
            im_wdata   = ld_wdata;
        end
    end

    always_comb begin
        owner_next = OWN_IDLE;
        if (if_gnt) begin
            owner_next = OWN_FETCH;
        end else if (ld_gnt) begin
            owner_next = OWN_LOAD;
        end
    end

    always_comb begin
        ld_run_next = ld_run_reg;
        if (!if_req || if_gnt) begin
            ld_run_next = '0;
        end else if (ld_gnt && (ld_run_reg != RUN_MAX)) begin
            ld_run_next = ld_run_reg + RUN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_reg   <= OWN_IDLE;
            ld_run_reg  <= '0;
            if_inst_reg <= '0;
        end else begin
            owner_reg  <= owner_next;
            ld_run_reg <= ld_run_next;
            if (if_gnt) begin
                if_inst_reg <= im_rdata;
            end
        end
    end

    // A fetch grant last cycle is exactly what marks if_inst as fresh.
    assign if_valid = (owner_reg == OWN_FETCH);
    assign if_inst  = if_inst_reg;

endmodule
